video_scandoubler: RTL and testbench
====================================

VIDEO_SCANDOUBLER -- requirements
Module: video_scandoubler

Interface
REQ-001 Parameter LINE_MAX, default 1024, sets the maximum captured pixels per input scanline.
REQ-002 Parameter HSYNC_W, default 48, sets the output h-sync pulse width in out_clk_en_i ticks.
REQ-003 Port sys_clock_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-005 Port pixel_clk_en_i, input, 1 bit: input pixel sample enable (8/16 MHz, one sys_clock_i cycle wide).
REQ-006 Port out_clk_en_i, input, 1 bit: output pixel enable at exactly twice the pixel_clk_en_i rate.
REQ-007 Port h_sync_i, input, 1 bit: input horizontal sync, normalized active-high.
REQ-008 Port v_sync_i, input, 1 bit: input vertical sync, normalized active-high.
REQ-009 Port video_i, input, 1 bit: input pixel, 1 = lit.
REQ-010 Port h_sync_o, output, 1 bit: doubled-rate horizontal sync, active-high.
REQ-011 Port v_sync_o, output, 1 bit: vertical sync realigned to output lines, active-high.
REQ-012 Port video_o, output, 1 bit: doubled-rate pixel, 1 = lit.
REQ-013 Port overflow_o, output, 1 bit: sticky flag; an input line exceeded LINE_MAX pixels.

Function
REQ-014 The block SHALL detect the h_sync_i rising edge ("line start") from a 1-cycle registered copy of h_sync_i.
REQ-015 Buffering SHALL be two banks of LINE_MAX x 1 bit in ping-pong: bank wbank is written, bank ~wbank is read.
REQ-016 On line start, the block SHALL toggle wbank, clear wcol to 0, and latch into len[old wbank] the old wcol.
REQ-017 On line start, the block SHALL latch into period the pixel_clk_en_i ticks counted since the previous line start, saturating at 2^11-1.
REQ-018 On each pixel_clk_en_i with wcol < LINE_MAX, the block SHALL write video_i to bank[wbank][wcol] and then increment wcol.
REQ-019 On pixel_clk_en_i with wcol == LINE_MAX, the block SHALL discard the pixel, hold wcol, and set overflow_o.
REQ-020 When pixel_clk_en_i coincides with line start, the pixel SHALL go to the new bank at column 0, and wcol SHALL become 1.
REQ-021 The read FSM SHALL have states IDLE, PASS0, PASS1; it uses rcol as the 11-bit output column counter.
REQ-022 Any line start SHALL force PASS0 with rcol = 0, including aborting PASS0/PASS1 in progress.
REQ-023 In PASS0/PASS1, rcol SHALL increment on each out_clk_en_i.
REQ-024 When rcol reaches period-1 on out_clk_en_i, PASS0 SHALL go to PASS1 with rcol = 0, and PASS1 SHALL go to IDLE.
REQ-025 If period == 0, the FSM SHALL stay in IDLE.
REQ-026 video_o SHALL be bank[~wbank][rcol] when in PASS0/PASS1 and rcol < len[~wbank]; otherwise video_o SHALL be 0.
REQ-027 h_sync_o SHALL be 1 while in PASS0/PASS1 and rcol < HSYNC_W; otherwise h_sync_o SHALL be 0.
REQ-028 v_sync_o SHALL take the value of v_sync_i sampled on each PASS0 entry and each PASS1 entry.
REQ-029 All outputs SHALL be registered; an output change SHALL appear 2 sys_clock_i cycles after the out_clk_en_i tick that advanced rcol (1 cycle RAM read + 1 cycle output register).
REQ-030 Write and read banks SHALL never coincide, so no read-during-write hazard exists.

Reset
REQ-031 On reset_i, the block SHALL force wbank=0, wcol=0, period=0, len[0]=len[1]=0, and FSM=IDLE, while buffer RAM contents remain undefined.
REQ-032 On reset_i, h_sync_o, v_sync_o, video_o, and overflow_o SHALL all be 0 on the next cycle.
REQ-033 Reset asserted mid-line SHALL abort capture and readout; the first line start after reset produces blank output, because len=0.
REQ-034 Only reset_i SHALL clear overflow_o.

Structure
REQ-035 VIDEO_LINE_MAX and the read FSM state enum SHALL live in common_pkg.
REQ-036 The buffer SHALL be sub-module video_line_buffer: a 2 x LINE_MAX x 1 simple dual-port RAM with 1-cycle synchronous read.

Verification
REQ-037 The bench SHALL check capture/readout: 40-col timing (8 MHz in, 16 MHz out) with a 512-pixel line of alternating 1/0, then the next line start -> two passes, each 512 out ticks, video_o = 1,0,1,0... for 512 pixels, and h_sync_o high for 48 ticks at each pass start.
REQ-038 The bench SHALL check short-line blanking: capture a 300-pixel line with period 512 -> video_o = 0 for rcol 300..511 in both passes.
REQ-039 The bench SHALL check overflow: a 1100-pixel line -> overflow_o = 1 after pixel 1024, len = 1024, and overflow_o stays 1 until reset_i.
REQ-040 The bench SHALL check early line start: h_sync_i rises at rcol 200 of PASS1 -> FSM is in PASS0 with rcol = 0 on the next cycle, and h_sync_o reasserts.
REQ-041 The bench SHALL check v_sync_o alignment: v_sync_i rises mid-line -> v_sync_o = 1 from the next PASS0 or PASS1 entry, not earlier.
REQ-042 The bench SHALL check reset mid-PASS0: all outputs = 0 the next cycle, and the first line after reset gives video_o = 0 throughout.

Source files
------------

// File: rtl/common_pkg.sv
// Shared constants and the scandoubler read-side state type.
package common_pkg;

    localparam int VIDEO_LINE_MAX = 1024;
    localparam int VIDEO_COL_W    = 11;
    localparam int VIDEO_HSYNC_W  = 48;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS0 = 2'd1,
        PASS1 = 2'd2
    } rd_state_t;

endpackage

// File: rtl/video_line_buffer.sv
// Two-bank line store: one write port, one registered read port, 1-cycle read latency.
module video_line_buffer
    import common_pkg::*;
#(
    parameter int LINE_MAX = VIDEO_LINE_MAX
) (
    input  logic                        sys_clock_i,
    input  logic                        wr_en,
    input  logic                        wr_bank,
    input  logic [$clog2(LINE_MAX)-1:0] wr_addr,
    input  logic                        wr_data,
    input  logic                        rd_bank,
    input  logic [$clog2(LINE_MAX)-1:0] rd_addr,
    output logic                        rd_data
);

    logic mem [0:1][0:LINE_MAX-1];

    // NOTE: the storage array has no reset on purpose; clearing it would stop it mapping onto block RAM,
    // and a line is never read back past the captured length anyway.
    // NOTE: state is updated with <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge sys_clock_i) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_bank][rd_addr];
    end

endmodule

// File: rtl/video_scandoubler.sv
// Line-doubling scan converter: captures each input line into one bank and replays the
// previous line twice at the doubled output pixel rate from the other bank.
module video_scandoubler
    import common_pkg::*;
#(
    parameter int LINE_MAX = VIDEO_LINE_MAX,
    parameter int HSYNC_W  = VIDEO_HSYNC_W
) (
    input  logic sys_clock_i,
    input  logic reset_i,
    input  logic pixel_clk_en_i,
    input  logic out_clk_en_i,
    input  logic h_sync_i,
    input  logic v_sync_i,
    input  logic video_i,
    output logic h_sync_o,
    output logic v_sync_o,
    output logic video_o,
    output logic overflow_o
);

    localparam int AW = $clog2(LINE_MAX);
    localparam int LW = $clog2(LINE_MAX + 1);
    localparam logic [VIDEO_COL_W-1:0] PERIOD_SAT = '1;

    logic                   h_sync_q;
    logic                   line_start;
    logic                   wbank;
    logic                   synced;
    logic [LW-1:0]          wcol;
    logic [LW-1:0]          len [2];
    logic [LW-1:0]          len_rd;
    logic                   wcol_full;
    logic [VIDEO_COL_W-1:0] tick_cnt;
    logic [VIDEO_COL_W-1:0] period;

    logic                   wr_en;
    logic                   wr_bank;
    logic [AW-1:0]          wr_addr;
    logic                   rd_bank;
    logic                   rd_data;

    rd_state_t              state;
    logic [VIDEO_COL_W-1:0] rcol;
    logic                   v_sync_q;
    logic                   vid_vld;
    logic                   hs_s1;
    logic                   vs_s1;

    assign line_start = h_sync_i & ~h_sync_q;
    assign wcol_full  = (wcol == LW'(LINE_MAX));
    assign rd_bank    = ~wbank;
    assign len_rd     = len[rd_bank];

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        wr_en   = 1'b0;
        wr_bank = wbank;
        wr_addr = wcol[AW-1:0];
        if (pixel_clk_en_i) begin
            if (line_start) begin
                wr_en   = 1'b1;
                wr_bank = ~wbank;
                wr_addr = '0;
            end else if (synced && !wcol_full) begin
                wr_en = 1'b1;
            end
        end
    end

    // Capture side; writes wait for the first line start so a line cut by reset is never replayed.
    always_ff @(posedge sys_clock_i) begin
        if (reset_i) begin
            h_sync_q   <= 1'b0;
            wbank      <= 1'b0;
            synced     <= 1'b0;
            wcol       <= '0;
            len[0]     <= '0;
            len[1]     <= '0;
            tick_cnt   <= '0;
            period     <= '0;
            overflow_o <= 1'b0;
        end else begin
            h_sync_q <= h_sync_i;
            if (line_start) begin
                wbank      <= ~wbank;
                synced     <= 1'b1;
                len[wbank] <= wcol;
                period     <= tick_cnt;
                wcol       <= pixel_clk_en_i ? LW'(1) : '0;
                tick_cnt   <= pixel_clk_en_i ? VIDEO_COL_W'(1) : '0;
            end else if (pixel_clk_en_i) begin
                if (tick_cnt != PERIOD_SAT) begin
                    tick_cnt <= tick_cnt + VIDEO_COL_W'(1);
                end
                if (synced) begin
                    if (wcol_full) begin
                        overflow_o <= 1'b1;
                    end else begin
                        wcol <= wcol + LW'(1);
                    end
                end
            end
        end
    end

    // Read FSM: each output pass lasts one input line period counted in output ticks.
    always_ff @(posedge sys_clock_i) begin
        if (reset_i) begin
            state    <= IDLE;
            rcol     <= '0;
            v_sync_q <= 1'b0;
        end else if (line_start) begin
            rcol <= '0;
            if (tick_cnt != '0) begin
                state    <= PASS0;
                v_sync_q <= v_sync_i;
            end else begin
                state <= IDLE;
            end
        end else if (out_clk_en_i && state != IDLE) begin
            if (rcol == period - VIDEO_COL_W'(1)) begin
                rcol <= '0;
                if (state == PASS0) begin
                    state    <= PASS1;
                    v_sync_q <= v_sync_i;
                end else begin
                    state <= IDLE;
                end
            end else begin
                rcol <= rcol + VIDEO_COL_W'(1);
            end
        end
    end

    video_line_buffer #(
        .LINE_MAX (LINE_MAX)
    ) u_buf (
        .sys_clock_i (sys_clock_i),
        .wr_en       (wr_en),
        .wr_bank     (wr_bank),
        .wr_addr     (wr_addr),
        .wr_data     (video_i),
        .rd_bank     (rd_bank),
        .rd_addr     (rcol[AW-1:0]),
        .rd_data     (rd_data)
    );

    // Stage 1 runs alongside the RAM read, stage 2 is the output register.
    always_ff @(posedge sys_clock_i) begin
        if (reset_i) begin
            vid_vld  <= 1'b0;
            hs_s1    <= 1'b0;
            vs_s1    <= 1'b0;
            video_o  <= 1'b0;
            h_sync_o <= 1'b0;
            v_sync_o <= 1'b0;
        end else begin
            vid_vld  <= (state != IDLE) && (32'(rcol) < 32'(len_rd));
            hs_s1    <= (state != IDLE) && (32'(rcol) < 32'(HSYNC_W));
            vs_s1    <= v_sync_q;
            video_o  <= vid_vld & rd_data;
            h_sync_o <= hs_s1;
            v_sync_o <= vs_s1;
        end
    end

endmodule

// File: tb/tb_video_scandoubler.sv
// Directed bench: pixel ticks every 4 clocks, output ticks every 2; each line replays the previous one.
module tb_video_scandoubler;

    localparam int NONE = 1 << 30;

    logic sys_clock_i = 1'b0;
    logic reset_i, pixel_clk_en_i, out_clk_en_i, h_sync_i, v_sync_i, video_i;
    logic h_sync_o, v_sync_o, video_o, overflow_o;

    int total = 0;
    int bad   = 0;
    int n     = 0;
    bit sticky_ovf = 1'b0;
    int t_a, t_b, t_c, t_d, t_e, t_f, t_g, t_h;

    video_scandoubler dut (
        .sys_clock_i    (sys_clock_i),
        .reset_i        (reset_i),
        .pixel_clk_en_i (pixel_clk_en_i),
        .out_clk_en_i   (out_clk_en_i),
        .h_sync_i       (h_sync_i),
        .v_sync_i       (v_sync_i),
        .video_i        (video_i),
        .h_sync_o       (h_sync_o),
        .v_sync_o       (v_sync_o),
        .video_o        (video_o),
        .overflow_o     (overflow_o)
    );

    always #5 sys_clock_i = ~sys_clock_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clock_i);
        @(negedge sys_clock_i);
        n++;
    endtask

    function automatic bit pix(input int kind, input int i);
        case (kind)
            0:       return (i % 2) == 0;
            1:       return i < 300;
            2:       return (i % 3) == 0;
            3:       return 1'b1;
            5:       return ((i / 2) % 2) == 1;
            default: return 1'b0;
        endcase
    endfunction

    // mode 1: full check of the replayed stream, mode 2: video must stay dark.
    task automatic run_line(input int ncyc, input int kind, input int mode, input int prev_ticks,
                            input int prev_kind, input int vs_rise, input int rst_c, output int ticks);
        int p, ln, k, j, r;
        bit vs0, vs1, rst_done, tick;
        logic ev, eh, evs;
        p  = prev_ticks;
        ln = (prev_ticks > 1024) ? 1024 : prev_ticks;
        vs0 = (vs_rise <= 0);
        vs1 = (vs_rise <= 2 * p);
        k = 0;
        rst_done = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            tick           = (n % 4) == 0;
            reset_i        = (c == rst_c);
            pixel_clk_en_i = tick;
            out_clk_en_i   = (n % 2) == 0;
            h_sync_i       = (c < 8);
            v_sync_i       = (c >= vs_rise);
            video_i        = tick ? pix(kind, k) : 1'b0;
            step();
            if (c == rst_c) begin
                rst_done   = 1'b1;
                sticky_ovf = 1'b0;
                check("rst video", video_o, 0);
                check("rst hsync", h_sync_o, 0);
                check("rst vsync", v_sync_o, 0);
                check("rst ovf", overflow_o, 0);
            end else begin
                if (tick) begin
                    k++;
                    if (!rst_done && k == 1024) check("ovf at 1024", overflow_o, sticky_ovf);
                    if (!rst_done && k == 1025) begin
                        sticky_ovf = 1'b1;
                        check("ovf at 1025", overflow_o, 1);
                    end
                end
                if (c >= 2 && c % 2 == 0) begin
                    j = (c - 2) / 2;
                    if (rst_done) begin
                        check($sformatf("post-rst vid j=%0d", j), video_o, 0);
                        check($sformatf("post-rst hs j=%0d", j), h_sync_o, 0);
                    end else if (mode == 2) begin
                        check($sformatf("blank vid j=%0d", j), video_o, 0);
                    end else if (mode == 1) begin
                        if (j < 2 * p) begin
                            r  = j % p;
                            ev = (r < ln) ? pix(prev_kind, r) : 1'b0;
                            eh = (r < 48);
                        end else begin
                            ev = 1'b0;
                            eh = 1'b0;
                        end
                        evs = (j < p) ? vs0 : vs1;
                        check($sformatf("vid j=%0d", j), video_o, ev);
                        check($sformatf("hs j=%0d", j), h_sync_o, eh);
                        check($sformatf("vs j=%0d", j), v_sync_o, evs);
                    end
                end
            end
        end
        reset_i  = 1'b0;
        v_sync_i = 1'b0;
        check("ovf line end", overflow_o, sticky_ovf);
        ticks = k;
    endtask

    initial begin
        reset_i        = 1'b1;
        pixel_clk_en_i = 1'b0;
        out_clk_en_i   = 1'b0;
        h_sync_i       = 1'b0;
        v_sync_i       = 1'b0;
        video_i        = 1'b0;
        repeat (3) step();
        check("reset video", video_o, 0);
        check("reset hsync", h_sync_o, 0);
        check("reset vsync", v_sync_o, 0);
        check("reset ovf", overflow_o, 0);
        reset_i = 1'b0;
        for (int i = 0; i < 4 || (n % 4) != 0; i++) begin
            pixel_clk_en_i = (n % 4) == 0;
            out_clk_en_i   = (n % 2) == 0;
            step();
        end

        run_line(2048, 0, 2, 0,    0, NONE, -1,  t_a);  // first line after reset: dark
        run_line(2048, 1, 1, t_a,  0, NONE, -1,  t_b);  // replay 512 alternating pixels
        run_line(1426, 2, 1, t_b,  1, 600,  -1,  t_c);  // 300 lit + blank; v_sync mid-line; cut at PASS1 rcol 200
        run_line(1428, 5, 1, t_c,  2, NONE, -1,  t_d);  // restart after early line start
        run_line(4400, 3, 1, t_d,  5, NONE, -1,  t_e);  // 1100-pixel line overflows
        run_line(4400, 5, 1, t_e,  3, NONE, -1,  t_f);  // replay capped at 1024
        run_line(2048, 3, 1, t_f,  5, NONE, 300, t_g);  // reset mid-PASS0
        run_line(2048, 3, 2, 0,    0, NONE, -1,  t_h);  // first line after reset: dark

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
